seg_scan_capture: RTL and testbench

Receive side of the CPU's multiplexed 7-segment display port: samples the segment bus `out` and digit-select bus `decoderout` exactly as the CPU drives them. Decodes each settled segment pattern back to a hex nibble and rebuilds the 4-digit displayed value. Presents completed frames on a valid/ready handshake for a self-checking bench or an on-chip monitor.

---
 rtl/seg_pkg.sv | 45 ++++
 rtl/seg7_to_hex.sv | 34 +++
 rtl/seg_scan_capture.sv | 133 +++++++++++++
 tb/tb_seg_scan_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - Shared 7-segment pattern constants and digit-select helpers.
package seg_pkg;

   // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_NONE   = 4'hF;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } scan_pair_t;

   function automatic logic one_cold(input logic [3:0] an);
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold = 1'b1;
         default:                            one_cold = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] cold_index(input logic [3:0] an);
      case (an)
         4'b1101: cold_index = 2'd1;
         4'b1011: cold_index = 2'd2;
         4'b0111: cold_index = 2'd3;
         default: cold_index = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - Decodes an active-low 7-segment pattern back to a hex nibble.
module seg7_to_hex
   import seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nib_o,
   output logic       legal_o
);

   always_comb begin
      nib_o   = 4'h0;
      legal_o = 1'b1;
      case (seg_i)
         SEG_0:   nib_o = 4'h0;
         SEG_1:   nib_o = 4'h1;
         SEG_2:   nib_o = 4'h2;
         SEG_3:   nib_o = 4'h3;
         SEG_4:   nib_o = 4'h4;
         SEG_5:   nib_o = 4'h5;
         SEG_6:   nib_o = 4'h6;
         SEG_7:   nib_o = 4'h7;
         SEG_8:   nib_o = 4'h8;
         SEG_9:   nib_o = 4'h9;
         SEG_A:   nib_o = 4'hA;
         SEG_B:   nib_o = 4'hB;
         SEG_C:   nib_o = 4'hC;
         SEG_D:   nib_o = 4'hD;
         SEG_E:   nib_o = 4'hE;
         SEG_F:   nib_o = 4'hF;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - Rebuilds the 4-digit value from a multiplexed 7-segment scan.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] digits,
   output logic [3:0]  digit_ok,
   output logic [3:0]  bad_pat,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [15:0] frame_data,
   output logic        overrun
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   scan_pair_t  pair_s;
   scan_pair_t  prev_q, prev_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  ok_q, ok_d;
   logic [3:0]  bad_q, bad_d;
   logic [3:0]  seen_q, seen_d;
   logic        fv_q, fv_d;
   logic [15:0] fd_q, fd_d;
   logic        ov_q, ov_d;

   logic [3:0]  dec_nib;
   logic        dec_legal;
   logic        capture;
   logic        accept;
   logic        complete;
   logic [1:0]  sel;

   assign pair_s = {an_in, seg_in};

   seg7_to_hex u_dec (
      .seg_i   (seg_in),
      .nib_o   (dec_nib),
      .legal_o (dec_legal)
   );

   // Stability counter saturates so a held pair captures only once
   always_comb begin
      prev_d = pair_s;
      if (pair_s != prev_q) begin
         cnt_d = 4'd1;
      end else if (cnt_q == SETTLE_C) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   assign capture = (cnt_d == SETTLE_C) && (cnt_q != SETTLE_C) && one_cold(an_in);
   assign sel     = cold_index(an_in);
   assign accept  = fv_q && frame_ready;

   always_comb begin
      digits_d = digits_q;
      ok_d     = ok_q;
      bad_d    = bad_q;
      seen_d   = seen_q;
      fv_d     = fv_q;
      fd_d     = fd_q;
      ov_d     = ov_q;
      complete = 1'b0;

      if (capture) begin
         seen_d[sel] = 1'b1;
         if (dec_legal) begin
            digits_d[{sel, 2'b00} +: 4] = dec_nib;
            ok_d[sel]                   = 1'b1;
         end else begin
            ok_d[sel]  = 1'b0;
            bad_d[sel] = 1'b1;
         end
         if (seen_d == 4'hF) begin
            complete = 1'b1;
            seen_d   = 4'h0;
         end
      end

      // A frame retiring on this edge frees the slot for a new completion
      if (complete) begin
         if (!fv_q || accept) begin
            fv_d = 1'b1;
            fd_d = digits_d;
         end else begin
            ov_d = 1'b1;
         end
      end else if (accept) begin
         fv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= {AN_NONE, SEG_BLANK};
         cnt_q    <= 4'd0;
         digits_q <= 16'h0000;
         ok_q     <= 4'h0;
         bad_q    <= 4'h0;
         seen_q   <= 4'h0;
         fv_q     <= 1'b0;
         fd_q     <= 16'h0000;
         ov_q     <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         ok_q     <= ok_d;
         bad_q    <= bad_d;
         seen_q   <= seen_d;
         fv_q     <= fv_d;
         fd_q     <= fd_d;
         ov_q     <= ov_d;
      end
   end

   assign digits      = digits_q;
   assign digit_ok    = ok_q;
   assign bad_pat     = bad_q;
   assign frame_valid = fv_q;
   assign frame_data  = fd_q;
   assign overrun     = ov_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - Self-checking bench for seg_scan_capture.
module tb_seg_scan_capture;

   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic        frame_ready;
   logic [15:0] digits;
   logic [3:0]  digit_ok;
   logic [3:0]  bad_pat;
   logic        frame_valid;
   logic [15:0] frame_data;
   logic        overrun;

   always #5 clk = ~clk;

   seg_scan_capture #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .digits      (digits),
      .digit_ok    (digit_ok),
      .bad_pat     (bad_pat),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .overrun     (overrun)
   );

   logic [6:0]  hex_tab [16];
   logic [3:0]  ghost_tab [6];
   logic [3:0]  m_dig [4];
   logic [3:0]  m_ok, m_bad, m_seen;
   logic        m_fv, m_ov;
   logic [15:0] m_fd;
   int          n_checks = 0;
   int          n_errors = 0;
   int          rdy_mode;
   int          fv_cycles;
   logic [15:0] last_fd;
   logic [10:0] last_pair;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_digits();
      return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
   endfunction

   function automatic int lookup(input logic [6:0] s);
      int r = -1;
      for (int k = 0; k < 16; k++) if (hex_tab[k] == s) r = k;
      return r;
   endfunction

   // Reference: a capture is a digit update plus seen-mask bookkeeping, frames by slot occupancy
   task automatic model_edge(input logic r, input logic cap, input logic [3:0] an,
                             input logic [6:0] sg, input logic rdy);
      int zeros = 0;
      int idx = 0;
      int v;
      logic done = 1'b0;
      logic acc;
      if (r) begin
         for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
         m_ok = 0; m_bad = 0; m_seen = 0; m_fv = 0; m_fd = 0; m_ov = 0;
         return;
      end
      acc = m_fv && rdy;
      for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; idx = k; end
      if (cap && zeros == 1) begin
         v = lookup(sg);
         if (v >= 0) begin
            m_dig[idx] = 4'(v);
            m_ok[idx]  = 1'b1;
         end else begin
            m_ok[idx]  = 1'b0;
            m_bad[idx] = 1'b1;
         end
         m_seen[idx] = 1'b1;
         if (m_seen == 4'hF) begin
            done   = 1'b1;
            m_seen = 4'h0;
         end
      end
      if (done) begin
         if (!m_fv || acc) begin
            m_fv = 1'b1;
            m_fd = m_digits();
         end else begin
            m_ov = 1'b1;
         end
      end else if (acc) begin
         m_fv = 1'b0;
      end
   endtask

   task automatic compare_all();
      check_eq("digits", digits, m_digits());
      check_eq("digit_ok", {12'h0, digit_ok}, {12'h0, m_ok});
      check_eq("bad_pat", {12'h0, bad_pat}, {12'h0, m_bad});
      check_eq("frame_valid", {15'h0, frame_valid}, {15'h0, m_fv});
      check_eq("frame_data", frame_data, m_fd);
      check_eq("overrun", {15'h0, overrun}, {15'h0, m_ov});
      if (frame_valid === 1'b1) begin
         fv_cycles++;
         last_fd = frame_data;
      end
   endtask

   function automatic logic pick_ready();
      if (rdy_mode == 0) return 1'b0;
      if (rdy_mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // Drive one pair for len cycles; position len-from-start decides the capture edge
   task automatic run_seg(input logic [3:0] an, input logic [6:0] sg, input int len);
      logic rdy;
      for (int j = 0; j < len; j++) begin
         an_in       = an;
         seg_in      = sg;
         rdy         = pick_ready();
         frame_ready = rdy;
         @(posedge clk);
         model_edge(1'b0, j == SETTLE - 1, an, sg, rdy);
         @(negedge clk);
         compare_all();
      end
      last_pair = {an, sg};
   endtask

   task automatic pulse_rst(input int n);
      logic rdy;
      for (int j = 0; j < n; j++) begin
         rst         = 1'b1;
         rdy         = pick_ready();
         frame_ready = rdy;
         @(posedge clk);
         model_edge(1'b1, 1'b0, an_in, seg_in, rdy);
         @(negedge clk);
         compare_all();
      end
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] an;
      logic [6:0] sg;
      int         kind;

      hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      ghost_tab = '{4'b1100, 4'b0101, 4'b0000, 4'b1001, 4'b0110, 4'b1010};
      rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F; frame_ready = 1'b0;
      rdy_mode = 0; fv_cycles = 0; last_fd = 16'h0; last_pair = 11'h7FF;
      @(negedge clk);
      pulse_rst(2);

      // Scan 1,2,3,4 with ready high
      rdy_mode = 1;
      fv_cycles = 0;
      run_seg(4'b1110, hex_tab[1], 6);
      run_seg(4'b1101, hex_tab[2], 6);
      run_seg(4'b1011, hex_tab[3], 6);
      run_seg(4'b0111, hex_tab[4], 6);
      check_eq("scan1_digits", digits, 16'h4321);
      check_eq("scan1_frame", last_fd, 16'h4321);
      check_eq("scan1_pulse", 16'(fv_cycles), 16'd1);

      // Short hold: no capture
      run_seg(4'b1011, hex_tab[9], 3);
      check_eq("short_hold", {12'h0, digits[11:8]}, 16'h3);

      // Illegal pattern on digit 1
      run_seg(4'b1101, 7'b1111110, 6);
      check_eq("illegal_ok", {15'h0, digit_ok[1]}, 16'h0);
      check_eq("illegal_bad", {15'h0, bad_pat[1]}, 16'h1);
      check_eq("illegal_keep", {12'h0, digits[7:4]}, 16'h2);

      // Two scans with ready low
      rdy_mode = 0;
      run_seg(4'b1110, hex_tab[5], 6);
      run_seg(4'b1101, hex_tab[6], 6);
      run_seg(4'b1011, hex_tab[7], 6);
      run_seg(4'b0111, hex_tab[8], 6);
      run_seg(4'b1110, hex_tab[9], 6);
      run_seg(4'b1101, hex_tab[10], 6);
      run_seg(4'b1011, hex_tab[11], 6);
      run_seg(4'b0111, hex_tab[12], 6);
      check_eq("hold_frame", frame_data, 16'h8765);
      check_eq("hold_overrun", {15'h0, overrun}, 16'h1);
      check_eq("hold_valid", {15'h0, frame_valid}, 16'h1);
      rdy_mode = 1;
      run_seg(4'hF, 7'h7F, 1);
      check_eq("ready_drop", {15'h0, frame_valid}, 16'h0);

      // Ghosting and blank selects change nothing
      run_seg(4'b1100, hex_tab[1], 10);
      run_seg(4'hF, hex_tab[8], 10);
      check_eq("ghost_digits", digits, 16'hCBA9);

      // Reset mid-scan, then a clean frame
      run_seg(4'b1110, hex_tab[5], 6);
      run_seg(4'b1101, hex_tab[6], 6);
      run_seg(4'b1011, hex_tab[7], 2);
      pulse_rst(1);
      check_eq("rst_digits", digits, 16'h0);
      check_eq("rst_ok", {12'h0, digit_ok}, 16'h0);
      check_eq("rst_bad", {12'h0, bad_pat}, 16'h0);
      check_eq("rst_overrun", {15'h0, overrun}, 16'h0);
      last_fd = 16'h0;
      fv_cycles = 0;
      run_seg(4'b1110, hex_tab[1], 6);
      run_seg(4'b1101, hex_tab[2], 6);
      run_seg(4'b1011, hex_tab[3], 6);
      run_seg(4'b0111, hex_tab[4], 6);
      check_eq("post_rst_frame", last_fd, 16'h4321);
      check_eq("post_rst_overrun", {15'h0, overrun}, 16'h0);
      check_eq("post_rst_pulse", 16'(fv_cycles), 16'd1);

      // Randomized scan traffic
      rdy_mode = 2;
      for (int s = 0; s < 400; s++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            an = 4'hF;
         end else if (kind == 1) begin
            an = ghost_tab[$urandom_range(0, 5)];
         end else begin
            an = 4'hF;
            an[$urandom_range(0, 3)] = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) sg = 7'($urandom);
         else sg = hex_tab[$urandom_range(0, 15)];
         if ({an, sg} == last_pair) sg = sg ^ 7'h01;
         if ($urandom_range(0, 49) == 0) pulse_rst(1);
         run_seg(an, sg, int'($urandom_range(1, 8)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
